// File: rtl/rf_burst_gen_if.sv
// Command/status bundle between burst control logic and rf_burst_gen.
// master drives the command side; slave is the generator.
interface rf_burst_gen_if;
    logic       start;
    logic [7:0] burst_len;
    logic       abort;
    logic       rfout;
    logic       busy;
    logic       done;
    logic [7:0] pulse_cnt;

    modport master (
        output start, burst_len, abort,
        input  rfout, busy, done, pulse_cnt
    );

    modport slave (
        input  start, burst_len, abort,
        output rfout, busy, done, pulse_cnt
    );
endinterface

// File: rtl/rf_burst_gen.sv
// Burst generator of fixed-width, fixed-gap pulses on rfout for the RF-input detector.
// Define RF_BURST_GEN_ABORT_EN to let abort end a running burst early.
module rf_burst_gen #(
    parameter int unsigned CNT_W   = 21,
    parameter int unsigned PULSE_W = 100,
    parameter int unsigned GAP_W   = 10000
) (
    input logic           clk,
    input logic           rst,
    rf_burst_gen_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

    localparam logic [CNT_W-1:0] PulseLast = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GapLast   = CNT_W'(GAP_W - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             rfout_q, rfout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             abort_hit;
    logic             pulse_end, gap_end, last_pulse;

`ifdef RF_BURST_GEN_ABORT_EN
    assign abort_hit = bus.abort && busy_q;
`else
    logic unused_abort;
    assign unused_abort = bus.abort;
    assign abort_hit    = 1'b0;
`endif

    assign pulse_end  = (timer_q == PulseLast);
    assign gap_end    = (timer_q == GapLast);
    // cnt_q already includes the pulse just finished when the gap ends
    assign last_pulse = (cnt_q == len_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            timer_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            rfout_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            rfout_q <= rfout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            StIdle: begin
                if (bus.start && (bus.burst_len != 8'd0)) begin
                    state_d = StPulse;
                    timer_d = '0;
                end
            end
            StPulse: begin
                if (pulse_end) begin
                    state_d = StGap;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_end) begin
                    state_d = last_pulse ? StIdle : StPulse;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
        if (abort_hit) begin
            state_d = StIdle;
            timer_d = '0;
        end
    end

    always_comb begin
        rfout_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    cnt_d = '0;
                    if (bus.burst_len != 8'd0) begin
                        len_d   = bus.burst_len;
                        rfout_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StPulse: begin
                busy_d = 1'b1;
                if (pulse_end) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    rfout_d = 1'b1;
                end
            end
            StGap: begin
                busy_d = 1'b1;
                if (gap_end) begin
                    if (last_pulse) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        rfout_d = 1'b1;
                    end
                end
            end
            default: busy_d = 1'b0;
        endcase
        if (abort_hit) begin
            rfout_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    assign bus.rfout     = rfout_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pulse_cnt = cnt_q;

endmodule

// File: tb/tb_rf_burst_gen.sv
// Bench for rf_burst_gen: vector table with a scoreboard queue, corner-case sequences,
// and a loopback into a behavioural model of the RF-input detector.
module tb_rf_burst_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rf_burst_gen_if bus ();
    rf_burst_gen_if bus2 ();

    rf_burst_gen #(
        .CNT_W  (21),
        .PULSE_W(4),
        .GAP_W  (6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    rf_burst_gen dut_loop (
        .clk(clk),
        .rst(rst),
        .bus(bus2)
    );

    typedef struct {
        int end_cyc;
        int done;
        int cnt;
        int rises;
        int high;
        int first_rise;
        int last_rise;
    } exp_t;

    typedef struct {
        int   len;
        int   start2_cyc;
        int   start2_len;
        int   abort_cyc;
        exp_t exp;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];
    vec_t vecs[5];

    // Detector model: a rising rfin opens a 10000-cycle active window
    int   det_entries = 0;
    int   det_merges  = 0;
    int   det_timer   = 0;
    logic det_active  = 1'b0;
    logic rf2_prev    = 1'b0;

    always @(posedge clk) begin
        rf2_prev <= bus2.rfout;
        if (det_active) begin
            if (bus2.rfout && !rf2_prev) det_merges <= det_merges + 1;
            if (det_timer == 9999) det_active <= 1'b0;
            det_timer <= det_timer + 1;
        end else if (bus2.rfout && !rf2_prev) begin
            det_active  <= 1'b1;
            det_timer   <= 1;
            det_entries <= det_entries + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start sampled at the next rising edge (cycle 0); returns just after it
    task automatic start_burst(input int len);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.burst_len = 8'(len);
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic run_vector(input int idx);
        vec_t v;
        exp_t e;
        int   rises, high, first_r, last_r, end_c, done_v, cnt_v;
        logic prev_rf, busy_seen, ended;
        v         = vecs[idx];
        rises     = 0;
        high      = 0;
        first_r   = 0;
        last_r    = 0;
        end_c     = -1;
        done_v    = 0;
        cnt_v     = 0;
        prev_rf   = 1'b0;
        busy_seen = 1'b0;
        ended     = 1'b0;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.burst_len = 8'(v.len);
        sb_q.push_back(v.exp);
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= 60 && !ended; c++) begin
            @(negedge clk);
            if (bus.rfout) begin
                high++;
                if (!prev_rf) begin
                    rises++;
                    if (first_r == 0) first_r = c;
                    last_r = c;
                end
            end
            prev_rf = bus.rfout;
            if (bus.busy) busy_seen = 1'b1;
            if (bus.done || (busy_seen && !bus.busy)) begin
                ended  = 1'b1;
                end_c  = c;
                done_v = int'(bus.done);
                cnt_v  = int'(bus.pulse_cnt);
            end
            if (c == v.start2_cyc) begin
                bus.start     = 1'b1;
                bus.burst_len = 8'(v.start2_len);
            end
            if (c == v.abort_cyc) bus.abort = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.abort = 1'b0;
        end
        e = sb_q.pop_front();
        if (!ended) $display("FAIL vec%0d_timeout: got no end of burst expected cycle %0d", idx,
                             e.end_cyc);
        check($sformatf("vec%0d_end_cycle", idx), end_c, e.end_cyc);
        check($sformatf("vec%0d_done", idx), done_v, e.done);
        check($sformatf("vec%0d_pulse_cnt", idx), cnt_v, e.cnt);
        check($sformatf("vec%0d_rises", idx), rises, e.rises);
        check($sformatf("vec%0d_high_cycles", idx), high, e.high);
        check($sformatf("vec%0d_first_rise", idx), first_r, e.first_rise);
        check($sformatf("vec%0d_last_rise", idx), last_r, e.last_rise);
        wait_cycles(2);
    endtask

    initial begin
        int lp_end;
        bus.start      = 1'b0;
        bus.burst_len  = 8'd0;
        bus.abort      = 1'b0;
        bus2.start     = 1'b0;
        bus2.burst_len = 8'd0;
        bus2.abort     = 1'b0;

        vecs[0] = '{1, 0, 0, 0, '{11, 1, 1, 1, 4, 1, 1}};
        vecs[1] = '{3, 0, 0, 0, '{31, 1, 3, 3, 12, 1, 21}};
        vecs[2] = '{0, 0, 0, 0, '{1, 1, 0, 0, 0, 0, 0}};
        vecs[3] = '{1, 3, 5, 0, '{11, 1, 1, 1, 4, 1, 1}};
`ifdef RF_BURST_GEN_ABORT_EN
        vecs[4] = '{3, 0, 0, 13, '{14, 0, 1, 2, 7, 1, 11}};
`else
        vecs[4] = '{3, 0, 0, 13, '{31, 1, 3, 3, 12, 1, 21}};
`endif

        // Reset held, then released
        wait_cycles(3);
        check("reset_held_outputs", int'({bus.rfout, bus.busy, bus.done, bus.pulse_cnt}), 0);
        rst = 1'b1;
        wait_cycles(2);
        check("reset_released_outputs", int'({bus.rfout, bus.busy, bus.done, bus.pulse_cnt}), 0);

        for (int i = 0; i < 5; i++) run_vector(i);

        // pulse_cnt steps in the cycle rfout falls
        start_burst(3);
        wait_cycles(4);
        check("step_c4_cnt", int'(bus.pulse_cnt), 0);
        check("step_c4_rfout", int'(bus.rfout), 1);
        wait_cycles(1);
        check("step_c5_cnt", int'(bus.pulse_cnt), 1);
        check("step_c5_rfout", int'(bus.rfout), 0);
        wait_cycles(9);
        check("step_c14_cnt", int'(bus.pulse_cnt), 1);
        wait_cycles(1);
        check("step_c15_cnt", int'(bus.pulse_cnt), 2);
        wait_cycles(10);
        check("step_c25_cnt", int'(bus.pulse_cnt), 3);
        wait_cycles(6);
        check("step_c31_done", int'(bus.done), 1);
        wait_cycles(2);
        check("idle_hold_cnt", int'(bus.pulse_cnt), 3);

        // Back-to-back: new start accepted in the done cycle
        start_burst(1);
        wait_cycles(11);
        check("b2b_done_c11", int'(bus.done), 1);
        bus.start     = 1'b1;
        bus.burst_len = 8'd1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("b2b_rfout_c12", int'(bus.rfout), 1);
        check("b2b_busy_c12", int'(bus.busy), 1);
        check("b2b_cnt_cleared", int'(bus.pulse_cnt), 0);
        wait_cycles(10);
        check("b2b_done_c22", int'(bus.done), 1);
        check("b2b_cnt_c22", int'(bus.pulse_cnt), 1);

        // Asynchronous reset in the middle of the second pulse
        start_burst(2);
        wait_cycles(12);
        check("midrst_pre_rfout", int'(bus.rfout), 1);
        check("midrst_pre_cnt", int'(bus.pulse_cnt), 1);
        #2 rst = 1'b0;
        #1;
        check("midrst_async_outputs", int'({bus.rfout, bus.busy, bus.pulse_cnt}), 0);
        @(negedge clk);
        rst = 1'b1;
        wait_cycles(3);
        check("midrst_after_idle", int'({bus.rfout, bus.busy, bus.done}), 0);

        // Loopback into the detector model with default timing
        @(negedge clk);
        bus2.start     = 1'b1;
        bus2.burst_len = 8'd4;
        @(posedge clk);
        #1 bus2.start = 1'b0;
        lp_end = -1;
        for (int c = 1; c <= 41000 && lp_end < 0; c++) begin
            @(negedge clk);
            if (bus2.done) lp_end = c;
        end
        check("loop_done_cycle", lp_end, 40401);
        check("loop_pulse_cnt", int'(bus2.pulse_cnt), 4);
        check("loop_det_entries", det_entries, 4);
        check("loop_det_merges", det_merges, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
